// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter: frame builder, baud divider, bit sequencer and
// output register. Configuration is latched when a word is accepted.
//
// state    | meaning
// ---------+-----------------------------------------------
// S_IDLE   | line high, tx_ready=1, waiting for tx_valid
// S_START  | start bit (0)
// S_DATA   | data bits, LSB first
// S_PARITY | parity bit (only when the latched mode has one)
// S_STOP   | one or two stop bits (1)
module uart_tx_param #(
  parameter int MAX_DATA  = 9,
  parameter int DIV_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DIV_WIDTH-1:0] baud_div,
  input  logic [3:0]           data_bits,
  input  logic [2:0]           parity_mode,
  input  logic                 stop_bits,
  input  logic                 tx_valid,
  input  logic [MAX_DATA-1:0]  tx_data,
  output logic                 tx_ready,
  output logic                 serial_out,
  output logic                 busy,
  output logic                 frame_done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t               state_q, state_d;
  logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
  logic [DIV_WIDTH-1:0] div_q, div_d;
  logic [MAX_DATA-1:0]  shreg_q, shreg_d;
  logic [3:0]           nbits_q, nbits_d;
  logic [3:0]           bit_cnt_q, bit_cnt_d;
  logic                 has_par_q, has_par_d;
  logic                 par_bit_q, par_bit_d;
  logic                 two_stop_q, two_stop_d;
  logic                 stop_left_q, stop_left_d;
  logic                 serial_q, serial_d;

  logic [3:0] nbits_clamp;
  logic       data_xor;
  logic       mode_has_par;
  logic       mode_par_bit;
  logic       bit_end;

  always_comb begin
    nbits_clamp = data_bits;
    if (data_bits < 4'd5) begin
      nbits_clamp = 4'd5;
    end else if (data_bits > 4'(MAX_DATA)) begin
      nbits_clamp = 4'(MAX_DATA);
    end
  end

  // Parity covers only the bits that will actually be shifted out.
  always_comb begin
    data_xor = 1'b0;
    for (int i = 0; i < MAX_DATA; i++) begin
      if (i < int'(nbits_clamp)) begin
        data_xor = data_xor ^ tx_data[i];
      end
    end
  end

  always_comb begin
    mode_has_par = 1'b0;
    mode_par_bit = 1'b0;
    case (parity_mode)
      3'b001: begin mode_has_par = 1'b1; mode_par_bit = data_xor;  end
      3'b010: begin mode_has_par = 1'b1; mode_par_bit = ~data_xor; end
      3'b011: begin mode_has_par = 1'b1; mode_par_bit = 1'b1;      end
      3'b100: begin mode_has_par = 1'b1; mode_par_bit = 1'b0;      end
      default: begin mode_has_par = 1'b0; mode_par_bit = 1'b0;     end
    endcase
  end

  assign bit_end = (cnt_q == '0);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    div_d       = div_q;
    shreg_d     = shreg_q;
    nbits_d     = nbits_q;
    bit_cnt_d   = bit_cnt_q;
    has_par_d   = has_par_q;
    par_bit_d   = par_bit_q;
    two_stop_d  = two_stop_q;
    stop_left_d = stop_left_q;
    serial_d    = serial_q;

    if (state_q != S_IDLE) begin
      cnt_d = bit_end ? div_q : cnt_q - DIV_WIDTH'(1);
    end

    case (state_q)
      S_IDLE: begin
        serial_d = 1'b1;
        if (tx_valid) begin
          state_d    = S_START;
          cnt_d      = baud_div;
          div_d      = baud_div;
          shreg_d    = tx_data;
          nbits_d    = nbits_clamp;
          has_par_d  = mode_has_par;
          par_bit_d  = mode_par_bit;
          two_stop_d = stop_bits;
          serial_d   = 1'b0;
        end
      end
      S_START: begin
        if (bit_end) begin
          state_d   = S_DATA;
          bit_cnt_d = nbits_q - 4'd1;
          serial_d  = shreg_q[0];
        end
      end
      S_DATA: begin
        if (bit_end) begin
          if (bit_cnt_q != 4'd0) begin
            bit_cnt_d = bit_cnt_q - 4'd1;
            shreg_d   = shreg_q >> 1;
            serial_d  = shreg_q[1];
          end else if (has_par_q) begin
            state_d  = S_PARITY;
            serial_d = par_bit_q;
          end else begin
            state_d     = S_STOP;
            stop_left_d = two_stop_q;
            serial_d    = 1'b1;
          end
        end
      end
      S_PARITY: begin
        if (bit_end) begin
          state_d     = S_STOP;
          stop_left_d = two_stop_q;
          serial_d    = 1'b1;
        end
      end
      S_STOP: begin
        if (bit_end) begin
          if (stop_left_q) begin
            stop_left_d = 1'b0;
          end else begin
            state_d = S_IDLE;
            cnt_d   = '0;
          end
        end
      end
      default: begin
        state_d  = S_IDLE;
        cnt_d    = '0;
        serial_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      div_q       <= '0;
      shreg_q     <= '0;
      nbits_q     <= 4'd5;
      bit_cnt_q   <= '0;
      has_par_q   <= 1'b0;
      par_bit_q   <= 1'b0;
      two_stop_q  <= 1'b0;
      stop_left_q <= 1'b0;
      serial_q    <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      div_q       <= div_d;
      shreg_q     <= shreg_d;
      nbits_q     <= nbits_d;
      bit_cnt_q   <= bit_cnt_d;
      has_par_q   <= has_par_d;
      par_bit_q   <= par_bit_d;
      two_stop_q  <= two_stop_d;
      stop_left_q <= stop_left_d;
      serial_q    <= serial_d;
    end
  end

  assign serial_out = serial_q;
  assign tx_ready   = (state_q == S_IDLE);
  assign busy       = (state_q != S_IDLE);
  assign frame_done = (state_q == S_STOP) && bit_end && !stop_left_q;

endmodule

// File: tb/tb_uart_tx_param.sv
// Directed bench for uart_tx_param: hand-computed frames, checked bit by bit
// each cycle with immediate assertions.
module tb_uart_tx_param;

  logic        clk;
  logic        rst_n;
  logic [15:0] baud_div;
  logic [3:0]  data_bits;
  logic [2:0]  parity_mode;
  logic        stop_bits;
  logic        tx_valid;
  logic [8:0]  tx_data;
  logic        tx_ready;
  logic        serial_out;
  logic        busy;
  logic        frame_done;

  int checks = 0;
  int errors = 0;

  uart_tx_param #(.MAX_DATA(9), .DIV_WIDTH(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .baud_div   (baud_div),
    .data_bits  (data_bits),
    .parity_mode(parity_mode),
    .stop_bits  (stop_bits),
    .tx_valid   (tx_valid),
    .tx_data    (tx_data),
    .tx_ready   (tx_ready),
    .serial_out (serial_out),
    .busy       (busy),
    .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge in IDLE with tx_valid=1. exp[i] is the i-th bit on the
  // line. mode: 0 plain, 1 change config during DATA, 2 reset during data bit 3.
  task automatic check_frame(input string name, input logic [15:0] exp, input int len,
                             input int div, input bit hold, input int mode);
    chk({name, " ready_before"}, 32'(tx_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    if (!hold) tx_valid = 1'b0;
    for (int i = 0; i < len; i++) begin
      for (int j = 0; j <= div; j++) begin
        if (mode == 2 && i == 4 && j == 1) begin
          rst_n = 1'b0;
          @(posedge clk);
          @(negedge clk);
          rst_n = 1'b1;
          chk({name, " rst_serial"}, 32'(serial_out), 32'd1);
          chk({name, " rst_ready"}, 32'(tx_ready), 32'd1);
          chk({name, " rst_busy"}, 32'(busy), 32'd0);
          for (int k = 0; k < 6; k++) begin
            chk($sformatf("%s rst_no_done%0d", name, k), 32'(frame_done), 32'd0);
            chk($sformatf("%s rst_idle%0d", name, k), 32'(serial_out), 32'd1);
            @(negedge clk);
          end
          return;
        end
        if (mode == 1 && i == 3 && j == 0) begin
          parity_mode = 3'b001;
          stop_bits   = 1'b1;
        end
        chk($sformatf("%s bit%0d.%0d", name, i, j), 32'(serial_out), 32'(exp[i]));
        chk($sformatf("%s done%0d.%0d", name, i, j), 32'(frame_done),
            32'((i == len - 1) && (j == div)));
        chk($sformatf("%s ready%0d.%0d", name, i, j), 32'(tx_ready), 32'd0);
        chk($sformatf("%s busy%0d.%0d", name, i, j), 32'(busy), 32'd1);
        @(negedge clk);
      end
    end
    chk({name, " ready_after"}, 32'(tx_ready), 32'd1);
    chk({name, " idle_after"}, 32'(serial_out), 32'd1);
    chk({name, " done_after"}, 32'(frame_done), 32'd0);
  endtask

  task automatic setup(input logic [15:0] div, input logic [3:0] nb, input logic [2:0] pm,
                       input logic sb, input logic [8:0] d);
    baud_div    = div;
    data_bits   = nb;
    parity_mode = pm;
    stop_bits   = sb;
    tx_data     = d;
    tx_valid    = 1'b1;
  endtask

  initial begin
    rst_n       = 1'b0;
    tx_valid    = 1'b0;
    baud_div    = 16'd0;
    data_bits   = 4'd8;
    parity_mode = 3'b000;
    stop_bits   = 1'b0;
    tx_data     = 9'h000;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset serial", 32'(serial_out), 32'd1);
    chk("reset ready", 32'(tx_ready), 32'd1);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done", 32'(frame_done), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle no valid", 32'(serial_out), 32'd1);

    // 8N1, 0x55, 4 cycles per bit: 40 cycles, done in cycle 40, ready in 41
    setup(16'd3, 4'd8, 3'b000, 1'b0, 9'h055);
    check_frame("8n1_55", 16'h02AA, 10, 3, 1'b0, 0);

    // 7-bit 0x41 with two stop bits and each parity flavour
    setup(16'd0, 4'd7, 3'b001, 1'b1, 9'h041);
    check_frame("7e2_41", 16'h0682, 11, 0, 1'b0, 0);
    setup(16'd0, 4'd7, 3'b010, 1'b1, 9'h041);
    check_frame("7o2_41", 16'h0782, 11, 0, 1'b0, 0);
    setup(16'd0, 4'd7, 3'b011, 1'b1, 9'h041);
    check_frame("7m2_41", 16'h0782, 11, 0, 1'b0, 0);
    setup(16'd0, 4'd7, 3'b100, 1'b1, 9'h041);
    check_frame("7s2_41", 16'h0682, 11, 0, 1'b0, 0);

    // clamping at both ends and a reserved parity code
    setup(16'd0, 4'd3, 3'b000, 1'b0, 9'h1FF);
    check_frame("clamp_lo", 16'h007E, 7, 0, 1'b0, 0);
    setup(16'd0, 4'd15, 3'b000, 1'b0, 9'h155);
    check_frame("clamp_hi", 16'h06AA, 11, 0, 1'b0, 0);
    setup(16'd0, 4'd8, 3'b110, 1'b0, 9'h055);
    check_frame("par_rsvd", 16'h02AA, 10, 0, 1'b0, 0);

    // back-to-back with tx_valid held high
    setup(16'd1, 4'd8, 3'b000, 1'b0, 9'h0A5);
    check_frame("b2b_a5", 16'h034A, 10, 1, 1'b1, 0);
    tx_data = 9'h03C;
    check_frame("b2b_3c", 16'h0278, 10, 1, 1'b0, 0);

    // config change during DATA affects only the next frame (8E2, parity 0)
    setup(16'd1, 4'd8, 3'b000, 1'b0, 9'h055);
    check_frame("chg_cur", 16'h02AA, 10, 1, 1'b0, 1);
    tx_valid = 1'b1;
    check_frame("chg_next", 16'h0CAA, 12, 1, 1'b0, 0);

    // reset during data bit 3, then a clean frame
    setup(16'd3, 4'd8, 3'b000, 1'b0, 9'h055);
    check_frame("abort", 16'h02AA, 10, 3, 1'b0, 2);
    setup(16'd0, 4'd7, 3'b001, 1'b1, 9'h041);
    check_frame("after_rst", 16'h0682, 11, 0, 1'b0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
